imm_gen_pipe: RTL and testbench

- Pipelined, parametrised RISC-V immediate generator for the decode stage.
- Takes a 32-bit instruction word, the format select and a sideband tag over a valid/ready stream.
- Produces the XLEN-wide extended immediate one cycle later over a valid/ready stream, using a 2-entry skid so full throughput survives backpressure.
- Counts illegal format selects for debug.

---
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_imm_gen_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a valid/ready stream and a 2-entry skid.
// Optional feature: define IMM_GEN_ZIMM_EN to decode select 101 as the CSR zimm.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [2:0]           in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    typedef enum logic [2:0] {
        SRC_I = 3'b000,
        SRC_S = 3'b001,
        SRC_B = 3'b010,
        SRC_J = 3'b011,
        SRC_U = 3'b100,
        SRC_Z = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t new_entry;
    entry_t out_q;
    entry_t skid_q;
    logic   skid_full;
    logic   accept;
    logic   deliver;
    logic   unused_opcode;

    assign unused_opcode = ^in_instr[6:0];

    assign accept  = in_valid & in_ready;
    assign deliver = out_valid & out_ready;

    assign out_imm = out_q.imm;
    assign out_tag = out_q.tag;
    assign out_err = out_q.err;

    // Size casts of $signed operands sign-extend from the top instruction bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        new_entry     = '0;
        new_entry.tag = in_tag;
        case (imm_src_e'(in_imm_src))
            SRC_I: new_entry.imm = XLEN'($signed(in_instr[31:20]));
            SRC_S: new_entry.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            SRC_B: new_entry.imm = XLEN'($signed({in_instr[31], in_instr[7],
                                                  in_instr[30:25], in_instr[11:8], 1'b0}));
            SRC_J: new_entry.imm = XLEN'($signed({in_instr[31], in_instr[19:12],
                                                  in_instr[20], in_instr[30:21], 1'b0}));
            SRC_U: new_entry.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
`ifdef IMM_GEN_ZIMM_EN
            SRC_Z: new_entry.imm = XLEN'(in_instr[19:15]);
`else
            SRC_Z: new_entry.err = 1'b1;
`endif
            default: new_entry.err = 1'b1;
        endcase
    end

    // in_ready is its own flop tracking !skid_full, so it never depends on out_ready.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            skid_full <= 1'b0;
            in_ready  <= 1'b1;
        end else if (skid_full) begin
            if (deliver) begin
                out_q     <= skid_q;
                skid_full <= 1'b0;
                in_ready  <= 1'b1;
            end
        end else if (accept && out_valid && !out_ready) begin
            skid_full <= 1'b1;
            in_ready  <= 1'b0;
        end else if (accept) begin
            out_q     <= new_entry;
            out_valid <= 1'b1;
        end else if (deliver) begin
            out_valid <= 1'b0;
        end
    end

    // NOTE: skid payload has no reset; skid_full alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (!skid_full && accept && out_valid && !out_ready) begin
            skid_q <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            err_cnt <= '0;
        end else if (accept && new_entry.err && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe; a 32-bit instance with a 2-bit
// error counter and a 64-bit instance share the same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic [1:0]  err_cnt32;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;
    logic [7:0]  err_cnt64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(2)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32),
        .err_cnt(err_cnt32), .err_clr(err_clr)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ERR_CNT_W(8)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64),
        .err_cnt(err_cnt64), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [7:0] tag);
        in_valid   = v;
        in_instr   = instr;
        in_imm_src = src;
        in_tag     = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        err_clr = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_out_imm", 64'(out_imm32), 64'd0);
        check("rst_out_tag", 64'(out_tag32), 64'd0);
        check("rst_out_err", 64'(out_err32), 64'd0);
        check("rst_err_cnt", 64'(err_cnt32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd1);
        reset = 1'b0;

        // I-type, no backpressure
        drive(1'b1, 32'hFFF00093, 3'b000, 8'h11);
        tick();
        check("i_valid", 64'(out_valid32), 64'd1);
        check("i_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
        check("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("i_err", 64'(out_err32), 64'd0);
        check("i_tag", 64'(out_tag32), 64'h11);

        // S, B, J back to back
        drive(1'b1, 32'hFE512E23, 3'b001, 8'h21);
        tick();
        check("s_imm", 64'(out_imm32), 64'hFFFF_FFFC);
        check("s_tag", 64'(out_tag32), 64'h21);
        drive(1'b1, 32'hFE000CE3, 3'b010, 8'h22);
        tick();
        check("b_imm", 64'(out_imm32), 64'hFFFF_FFF8);
        check("b_tag", 64'(out_tag32), 64'h22);
        drive(1'b1, 32'hFFDFF06F, 3'b011, 8'h23);
        tick();
        check("j_imm", 64'(out_imm32), 64'hFFFF_FFFC);
        check("j_tag", 64'(out_tag32), 64'h23);
        check("j_valid", 64'(out_valid32), 64'd1);

        // U-type on both widths
        drive(1'b1, 32'h800000B7, 3'b100, 8'h30);
        tick();
        check("u_imm32", 64'(out_imm32), 64'h8000_0000);
        check("u_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check("u_err64", 64'(out_err64), 64'd0);

        // Drain
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        tick();
        check("drain_valid", 64'(out_valid32), 64'd0);

        // Backpressure: tag k carries I-immediate k
        drive(1'b1, 32'h00100093, 3'b000, 8'd1);
        tick();
        check("bp1_tag", 64'(out_tag32), 64'd1);
        check("bp1_ready", 64'(in_ready32), 64'd1);
        drive(1'b1, 32'h00200093, 3'b000, 8'd2);
        out_ready = 1'b0;
        tick();
        check("bp2_ready_low", 64'(in_ready32), 64'd0);
        check("bp2_tag_held", 64'(out_tag32), 64'd1);
        drive(1'b1, 32'h00300093, 3'b000, 8'd3);
        tick();
        check("bp3_imm_stable", 64'(out_imm32), 64'd1);
        check("bp3_ready_low", 64'(in_ready32), 64'd0);
        tick();
        check("bp4_imm_stable", 64'(out_imm32), 64'd1);
        check("bp4_valid", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp5_tag", 64'(out_tag32), 64'd2);
        check("bp5_imm", 64'(out_imm32), 64'd2);
        check("bp5_ready", 64'(in_ready32), 64'd1);
        tick();
        check("bp6_tag", 64'(out_tag32), 64'd3);
        drive(1'b1, 32'h00400093, 3'b000, 8'd4);
        tick();
        check("bp7_tag", 64'(out_tag32), 64'd4);
        check("bp7_imm", 64'(out_imm32), 64'd4);
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        tick();
        check("bp_drain", 64'(out_valid32), 64'd0);

        // Illegal selects and counter saturation (2-bit counter on dut32)
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'hFFFFFFFF, 3'b111, 8'(8'h40 + i));
            tick();
            check($sformatf("ill%0d_err", i), 64'(out_err32), 64'd1);
            check($sformatf("ill%0d_imm", i), 64'(out_imm32), 64'd0);
            check($sformatf("ill%0d_cnt", i), 64'(err_cnt32), 64'((i > 3) ? 3 : i));
        end
        check("ill_cnt64", 64'(err_cnt64), 64'd5);
        err_clr = 1'b1;
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 8'h46);
        tick();
        check("clr_cnt", 64'(err_cnt32), 64'd0);
        check("clr_err", 64'(out_err32), 64'd1);
        err_clr = 1'b0;
        drive(1'b1, 32'h12345678, 3'b110, 8'h47);
        tick();
        check("ill110_err", 64'(out_err32), 64'd1);
        check("ill110_cnt", 64'(err_cnt32), 64'd1);

        // Z select, instr[19:15] = 0x1F
        drive(1'b1, 32'h000F8073, 3'b101, 8'h50);
        tick();
`ifdef IMM_GEN_ZIMM_EN
        check("z_imm", 64'(out_imm32), 64'h1F);
        check("z_err", 64'(out_err32), 64'd0);
        check("z_cnt", 64'(err_cnt32), 64'd1);
`else
        check("z_imm", 64'(out_imm32), 64'd0);
        check("z_err", 64'(out_err32), 64'd1);
        check("z_cnt", 64'(err_cnt32), 64'd2);
`endif
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        tick();

        // Fill both entries, then reset
        out_ready = 1'b0;
        drive(1'b1, 32'h00700093, 3'b000, 8'h61);
        tick();
        drive(1'b1, 32'h00800093, 3'b000, 8'h62);
        tick();
        check("full_ready_low", 64'(in_ready32), 64'd0);
        check("full_tag", 64'(out_tag32), 64'h61);
        drive(1'b0, 32'h0, 3'b000, 8'h00);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 64'(out_valid32), 64'd0);
        check("mid_rst_ready", 64'(in_ready32), 64'd1);
        check("mid_rst_cnt", 64'(err_cnt32), 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 64'(out_valid32), 64'd0);
        check("post_rst_tag", 64'(out_tag32), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
